// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame timing.
package uart_pkg;

    // Ticks per bit period on the baudclk16 enable.
    localparam int OVERSAMPLE       = 16;
    // Default frame shape and mid-start-bit recheck point.
    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_START_SAMPLE = 7;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input pin.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic meta;

    // Resolve metastability over two stages; both flops come out of reset at the idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_16x.sv
// 8N1 receiver with 16x oversampling, holding register handshake,
// start glitch rejection, sticky framing-error and overrun flags.
module uart_rx_16x
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = DEF_DATA_BITS,
    parameter int START_SAMPLE = DEF_START_SAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baudclk16,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 ready,
    input  logic                 read,
    output logic                 framing_error,
    output logic                 overrun,
    input  logic                 err_clr
);

    localparam int CNT_W  = $clog2(OVERSAMPLE);
    localparam int BIDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]  CNT_START  = CNT_W'(START_SAMPLE);
    localparam logic [BIDX_W-1:0] BIDX_LAST  = BIDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [BIDX_W-1:0]    bitidx, bitidx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 load_pend, load_n;
    logic                 fe_set;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (rx),
        .dout  (rx_s)
    );

    // Frame state register; load_pend delays the holding-register update one edge past the stop sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bitidx    <= '0;
            shreg     <= '0;
            load_pend <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bitidx    <= bitidx_n;
            shreg     <= shreg_n;
            load_pend <= load_n;
        end
    end

    // Next-state logic: everything advances only on baudclk16 ticks.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bitidx_n = bitidx;
        shreg_n  = shreg;
        load_n   = 1'b0;
        fe_set   = 1'b0;
        if (baudclk16) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        cnt_n   = '0;
                    end
                end
                START: begin
                    // Recheck near mid start bit; a high line here was only a glitch.
                    if (cnt == CNT_START) begin
                        if (!rx_s) begin
                            state_n  = DATA;
                            cnt_n    = '0;
                            bitidx_n = '0;
                        end else begin
                            state_n  = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                DATA: begin
                    cnt_n = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // LSB arrives first, so shift in at the top and move right.
                        shreg_n  = {rx_s, shreg[DATA_BITS-1:1]};
                        bitidx_n = bitidx + 1'b1;
                        if (bitidx == BIDX_LAST) begin
                            state_n = STOP;
                            cnt_n   = '0;
                        end
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        if (rx_s) begin
                            load_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            fe_set  = 1'b1;
                            state_n = WAIT_HIGH;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // A break or stuck-low line must go idle before a new start is accepted.
                    if (rx_s) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Holding register, ready handshake and sticky flags; a new error or overrun beats err_clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            data          <= '0;
            ready         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (load_pend) begin
                data  <= shreg;
                ready <= 1'b1;
            end else if (read) begin
                ready <= 1'b0;
            end

            if (load_pend && ready && !read) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end

            if (fe_set) begin
                framing_error <= 1'b1;
            end else if (err_clr) begin
                framing_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed bench for uart_rx_16x: table of frames plus hand-written corner sequences.
module tb_uart_rx_16x;

    localparam int BIT_CLK = 272;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baudclk16 = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       read;
    logic       read_man = 1'b0;
    logic       auto_rd = 1'b0;
    logic       framing_error;
    logic       overrun;
    logic       err_clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int tcnt = 0;
    int lat;
    logic [7:0] got_q[$];

    assign read = auto_rd ? ready : read_man;

    uart_rx_16x dut (
        .clk           (clk),
        .reset         (reset),
        .baudclk16     (baudclk16),
        .rx            (rx),
        .data          (data),
        .ready         (ready),
        .read          (read),
        .framing_error (framing_error),
        .overrun       (overrun),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    // One tick every 17 clocks, changed on the falling edge.
    always @(negedge clk) begin
        if (tcnt == 16) begin
            tcnt = 0;
            baudclk16 = 1'b1;
        end else begin
            tcnt++;
            baudclk16 = 1'b0;
        end
    end

    // Record each byte presented while read follows ready.
    always @(negedge clk) begin
        if (auto_rd && ready) got_q.push_back(data);
    end

    typedef struct {
        logic [7:0] tx;
        logic       stop;
        int         hold;
        logic [7:0] exp_data;
        logic       exp_rdy;
        logic       exp_fe;
        logic       exp_ov;
        logic       do_read;
        logic       do_clr;
        logic       post_rdy;
        logic       post_fe;
        logic       post_ov;
    } vec_t;

    vec_t vecs[5];

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int hold);
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clk(BIT_CLK);
        end
        rx = stop;
        wait_clk(BIT_CLK);
        if (!stop && hold > 0) begin
            rx = 1'b0;
            wait_clk(BIT_CLK * hold);
        end
        rx = 1'b1;
        wait_clk(BIT_CLK);
    endtask

    task automatic pulse(input logic rd, input logic clr);
        read_man = rd;
        err_clr  = clr;
        wait_clk(1);
        read_man = 1'b0;
        err_clr  = 1'b0;
    endtask

    initial begin
        //                tx     stop hold exp_d  rdy  fe   ov   rd   clr  prdy pfe  pov
        vecs[0] = '{8'h96, 1'b1, 0, 8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 2, 8'h96, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h81, 1'b1, 0, 8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h11, 1'b1, 0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h22, 1'b1, 0, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset values
        wait_clk(5);
        check("rst_data", 32'(data), 32'h00);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_fe", 32'(framing_error), 32'h0);
        check("rst_ov", 32'(overrun), 32'h0);
        reset = 1'b0;
        wait_clk(BIT_CLK);

        // Clean byte with latency measurement
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                lat = 0;
                while (!ready && lat < 3200) begin
                    wait_clk(1);
                    lat++;
                end
            end
        join
        check("clean_ready_seen", 32'(lat < 3200), 32'h1);
        check("clean_latency_window", 32'(lat >= 2580 && lat <= 2612), 32'h1);
        check("clean_data", 32'(data), 32'hA5);
        check("clean_ready", 32'(ready), 32'h1);
        pulse(1'b1, 1'b0);
        check("clean_ready_after_read", 32'(ready), 32'h0);
        check("clean_fe", 32'(framing_error), 32'h0);
        check("clean_ov", 32'(overrun), 32'h0);
        pulse(1'b1, 1'b0);
        check("read_when_empty_ignored", 32'(ready), 32'h0);

        // Start glitch of 3 ticks
        rx = 1'b0;
        wait_clk(51);
        rx = 1'b1;
        wait_clk(BIT_CLK * 2);
        check("glitch_ready", 32'(ready), 32'h0);
        check("glitch_data", 32'(data), 32'hA5);
        check("glitch_fe", 32'(framing_error), 32'h0);
        send_frame(8'h3C, 1'b1, 0);
        check("post_glitch_data", 32'(data), 32'h3C);
        check("post_glitch_ready", 32'(ready), 32'h1);
        pulse(1'b1, 1'b0);

        // Table: clean, framing error, recovery, overrun pair
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].tx, vecs[v].stop, vecs[v].hold);
            check($sformatf("v%0d_data", v), 32'(data), 32'(vecs[v].exp_data));
            check($sformatf("v%0d_ready", v), 32'(ready), 32'(vecs[v].exp_rdy));
            check($sformatf("v%0d_fe", v), 32'(framing_error), 32'(vecs[v].exp_fe));
            check($sformatf("v%0d_ov", v), 32'(overrun), 32'(vecs[v].exp_ov));
            if (vecs[v].do_read || vecs[v].do_clr) pulse(vecs[v].do_read, vecs[v].do_clr);
            wait_clk(1);
            check($sformatf("v%0d_post_ready", v), 32'(ready), 32'(vecs[v].post_rdy));
            check($sformatf("v%0d_post_fe", v), 32'(framing_error), 32'(vecs[v].post_fe));
            check($sformatf("v%0d_post_ov", v), 32'(overrun), 32'(vecs[v].post_ov));
        end

        // Stream with read tied to ready
        got_q.delete();
        auto_rd = 1'b1;
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h55, 1'b1, 0);
        wait_clk(4);
        auto_rd = 1'b0;
        check("stream_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check("stream_b0", 32'(got_q[0]), 32'h00);
            check("stream_b1", 32'(got_q[1]), 32'hFF);
            check("stream_b2", 32'(got_q[2]), 32'h55);
        end
        check("stream_ov", 32'(overrun), 32'h0);
        check("stream_ready", 32'(ready), 32'h0);

        // Leave an unread byte, then reset during bit 4 of 0xC3
        send_frame(8'h99, 1'b1, 0);
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = (8'hC3 >> i) & 8'h01;
            wait_clk(BIT_CLK);
        end
        rx = 1'b0;
        wait_clk(BIT_CLK / 2);
        reset = 1'b1;
        wait_clk(3);
        rx = 1'b1;
        reset = 1'b0;
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_ready", 32'(ready), 32'h0);
        check("midrst_fe", 32'(framing_error), 32'h0);
        check("midrst_ov", 32'(overrun), 32'h0);
        wait_clk(BIT_CLK * 6);
        check("midrst_no_partial", 32'(ready), 32'h0);
        send_frame(8'h5A, 1'b1, 0);
        check("after_rst_data", 32'(data), 32'h5A);
        check("after_rst_ready", 32'(ready), 32'h1);
        check("after_rst_fe", 32'(framing_error), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
